// File: rtl/crc_check_strip.sv
// crc_check_strip: checks the CRC-32 residue of a received frame, strips the FCS and flags bad frames
module crc_check_strip #(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     aresetn,
    input  logic [7:0]               saxis_tdata,
    input  logic                     saxis_tvalid,
    output logic                     saxis_tready,
    input  logic                     saxis_tlast,
    input  logic                     saxis_tuser,
    output logic [7:0]               maxis_tdata,
    output logic                     maxis_tvalid,
    input  logic                     maxis_tready,
    output logic                     maxis_tlast,
    output logic                     maxis_tuser,
    output logic                     status_valid,
    output logic                     status_crc_error,
    output logic                     status_runt,
    output logic [COUNTER_WIDTH-1:0] frame_ok_count,
    output logic [COUNTER_WIDTH-1:0] frame_err_count
);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;
    logic [7:0]  hold [4];
    logic [2:0]  fill;
    logic [31:0] crc;
    logic [15:0] byte_cnt;
    logic        sticky;
    logic        accept;
    logic        full;
    logic [31:0] crc_next;
    logic [15:0] cnt_next;
    logic        sticky_next;
    logic        crc_bad;
    logic        runt;
    logic        frame_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign saxis_tready = !maxis_tvalid || maxis_tready;
    assign accept       = saxis_tvalid && saxis_tready;
    assign full         = fill == 3'd4;

    // Per-beat frame verdict; a frame that never filled the holdback is a runt regardless of MIN_FRAME_BYTES
    always_comb begin
        crc_next    = crc_byte(crc, saxis_tdata);
        cnt_next    = &byte_cnt ? byte_cnt : byte_cnt + 16'd1;
        sticky_next = sticky || saxis_tuser;
        crc_bad     = crc_next != RESIDUE;
        runt        = ({16'd0, cnt_next} < $unsigned(MIN_FRAME_BYTES)) || !full;
        frame_bad   = crc_bad || runt || sticky_next;
    end

    // Holdback shift register, output register, CRC/length tracking and status counters
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 4; i++) hold[i] <= 8'd0;
            fill             <= 3'd0;
            crc              <= CRC_INIT;
            byte_cnt         <= 16'd0;
            sticky           <= 1'b0;
            maxis_tdata      <= 8'd0;
            maxis_tvalid     <= 1'b0;
            maxis_tlast      <= 1'b0;
            maxis_tuser      <= 1'b0;
            status_valid     <= 1'b0;
            status_crc_error <= 1'b0;
            status_runt      <= 1'b0;
            frame_ok_count   <= '0;
            frame_err_count  <= '0;
        end else begin
            status_valid <= 1'b0;
            if (maxis_tready) maxis_tvalid <= 1'b0;
            if (accept) begin
                if (full) begin
                    maxis_tdata  <= hold[0];
                    maxis_tvalid <= 1'b1;
                    maxis_tlast  <= saxis_tlast;
                    maxis_tuser  <= saxis_tlast && frame_bad;
                    for (int i = 0; i < 3; i++) hold[i] <= hold[i+1];
                    hold[3] <= saxis_tdata;
                end else begin
                    hold[fill[1:0]] <= saxis_tdata;
                    fill            <= fill + 3'd1;
                end
                crc      <= crc_next;
                byte_cnt <= cnt_next;
                sticky   <= sticky_next;
                if (saxis_tlast) begin
                    fill             <= 3'd0;
                    crc              <= CRC_INIT;
                    byte_cnt         <= 16'd0;
                    sticky           <= 1'b0;
                    status_valid     <= 1'b1;
                    status_crc_error <= crc_bad;
                    status_runt      <= runt;
                    if (frame_bad && !(&frame_err_count)) frame_err_count <= frame_err_count + COUNTER_WIDTH'(1);
                    if (!frame_bad && !(&frame_ok_count)) frame_ok_count <= frame_ok_count + COUNTER_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_crc_check_strip.sv
// tb_crc_check_strip: scoreboard bench driving a MIN_FRAME_BYTES=5 and a default (64) instance in lockstep
module tb_crc_check_strip;
    logic        clock = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  saxis_tdata = 8'd0;
    logic        saxis_tvalid = 1'b0;
    logic        saxis_tlast = 1'b0;
    logic        saxis_tuser = 1'b0;
    logic        maxis_tready = 1'b1;
    logic        bp = 1'b0;
    logic        a_ready, b_ready, a_valid, b_valid, a_last, b_last, a_user, b_user;
    logic [7:0]  a_data, b_data;
    logic        a_sv, b_sv, a_crc, b_crc, a_runt, b_runt;
    logic [15:0] a_ok, b_ok, a_err, b_err;
    int          total = 0;
    int          bad = 0;
    int          oka = 0, erra = 0, okb = 0, errb = 0;

    typedef struct packed {logic [7:0] d; logic l; logic ua; logic ub;} beat_t;
    typedef struct packed {logic care; logic crc; logic ra; logic rb; logic ba; logic bb;} stat_t;
    beat_t       exp_q[$];
    stat_t       st_q[$];
    logic [7:0]  frm[$];
    logic [7:0]  good_frame [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                     8'h26, 8'h39, 8'hF4, 8'hCB};

    always #5 clock = ~clock;

    crc_check_strip #(.MIN_FRAME_BYTES(5)) dut_a (
        .clock(clock), .aresetn(aresetn),
        .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid), .saxis_tready(a_ready),
        .saxis_tlast(saxis_tlast), .saxis_tuser(saxis_tuser),
        .maxis_tdata(a_data), .maxis_tvalid(a_valid), .maxis_tready(maxis_tready),
        .maxis_tlast(a_last), .maxis_tuser(a_user),
        .status_valid(a_sv), .status_crc_error(a_crc), .status_runt(a_runt),
        .frame_ok_count(a_ok), .frame_err_count(a_err));

    crc_check_strip dut_b (
        .clock(clock), .aresetn(aresetn),
        .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid), .saxis_tready(b_ready),
        .saxis_tlast(saxis_tlast), .saxis_tuser(saxis_tuser),
        .maxis_tdata(b_data), .maxis_tvalid(b_valid), .maxis_tready(maxis_tready),
        .maxis_tlast(b_last), .maxis_tuser(b_user),
        .status_valid(b_sv), .status_crc_error(b_crc), .status_runt(b_runt),
        .frame_ok_count(b_ok), .frame_err_count(b_err));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: 30% duty when backpressure is enabled
    always @(negedge clock) maxis_tready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;

    // Monitor: values are stable from here until the next rising edge
    always @(negedge clock) begin
        #2;
        if (aresetn) begin
            chk("a_tready", {31'd0, a_ready}, {31'd0, !(a_valid && !maxis_tready)});
            chk("b_tready", {31'd0, b_ready}, {31'd0, a_ready});
            chk("b_tvalid", {31'd0, b_valid}, {31'd0, a_valid});
            if (a_valid && maxis_tready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got %h expected none", a_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("a_data", {24'd0, a_data}, {24'd0, e.d});
                    chk("a_last", {31'd0, a_last}, {31'd0, e.l});
                    chk("b_data", {24'd0, b_data}, {24'd0, e.d});
                    chk("b_last", {31'd0, b_last}, {31'd0, e.l});
                    if (e.l) begin
                        chk("a_user", {31'd0, a_user}, {31'd0, e.ua});
                        chk("b_user", {31'd0, b_user}, {31'd0, e.ub});
                    end
                end
            end
            chk("b_status_valid", {31'd0, b_sv}, {31'd0, a_sv});
            if (a_sv) begin
                if (st_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_status: got 1 expected 0");
                end else begin
                    stat_t s;
                    s = st_q.pop_front();
                    if (s.care) begin
                        chk("a_crc_error", {31'd0, a_crc}, {31'd0, s.crc});
                        chk("b_crc_error", {31'd0, b_crc}, {31'd0, s.crc});
                    end
                    chk("a_runt", {31'd0, a_runt}, {31'd0, s.ra});
                    chk("b_runt", {31'd0, b_runt}, {31'd0, s.rb});
                    if (s.ba) erra++; else oka++;
                    if (s.bb) errb++; else okb++;
                    chk("a_ok_count", {16'd0, a_ok}, oka);
                    chk("a_err_count", {16'd0, a_err}, erra);
                    chk("b_ok_count", {16'd0, b_ok}, okb);
                    chk("b_err_count", {16'd0, b_err}, errb);
                end
            end
        end
    end

    task automatic load_good(input logic [7:0] last_byte);
        frm = {};
        foreach (good_frame[i]) frm.push_back(good_frame[i]);
        frm[12] = last_byte;
    endtask

    task automatic send(input bit care, input bit crc_bad, input int phy);
        int    n;
        int    guard;
        beat_t e;
        stat_t s;
        n = frm.size();
        s.care = care;
        s.crc  = crc_bad;
        s.ra   = n < 5;
        s.rb   = n < 64;
        s.ba   = (care && crc_bad) || phy >= 0 || n < 5;
        s.bb   = (care && crc_bad) || phy >= 0 || n < 64;
        for (int i = 0; i + 4 < n; i++) begin
            e.d  = frm[i];
            e.l  = (i == n - 5);
            e.ua = s.ba;
            e.ub = s.bb;
            exp_q.push_back(e);
        end
        st_q.push_back(s);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            saxis_tvalid = 1'b1;
            saxis_tdata  = frm[i];
            saxis_tlast  = (i == n - 1);
            saxis_tuser  = (i == phy);
            #1;
            guard = 0;
            while (!a_ready) begin
                @(negedge clock);
                #1;
                if (++guard > 1000) begin
                    $display("FAIL input_stall: got tready=0 expected 1 within 1000 cycles");
                    $fatal(1);
                end
            end
        end
    endtask

    task automatic idle_drain();
        @(negedge clock);
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        saxis_tuser  = 1'b0;
        bp = 1'b0;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || st_q.size() != 0); i++) @(negedge clock);
        repeat (2) @(negedge clock);
        chk("beats_pending", exp_q.size(), 0);
        chk("status_pending", st_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500us");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_tvalid", {31'd0, a_valid}, 0);
        chk("rst_tlast", {31'd0, a_last}, 0);
        chk("rst_tuser", {31'd0, a_user}, 0);
        chk("rst_tdata", {24'd0, a_data}, 0);
        chk("rst_status", {29'd0, a_sv, a_crc, a_runt}, 0);
        chk("rst_counts", {a_ok, a_err}, 0);
        aresetn = 1'b1;
        load_good(8'hCB); send(1, 0, -1);
        load_good(8'hCA); send(1, 1, -1);
        idle_drain();
        frm = {8'hAA, 8'hBB, 8'hCC}; send(0, 0, -1);
        load_good(8'hCB); send(1, 0, -1);
        idle_drain();
        bp = 1'b1;
        for (int k = 0; k < 5; k++) begin
            load_good(k == 2 ? 8'hCA : 8'hCB);
            send(1, k == 2, -1);
        end
        idle_drain();
        load_good(8'hCB); send(1, 0, 4);
        idle_drain();
        load_good(8'hCB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            saxis_tvalid = 1'b1;
            saxis_tdata  = frm[i];
        end
        @(negedge clock);
        saxis_tvalid = 1'b0;
        #3 aresetn = 1'b0;
        #1;
        chk("midrst_outputs", {28'd0, a_valid, a_last, a_user, a_sv}, 0);
        chk("midrst_data_counts", {a_data, a_ok[7:0], a_err}, 0);
        oka = 0; erra = 0; okb = 0; errb = 0;
        repeat (2) @(negedge clock);
        aresetn = 1'b1;
        load_good(8'hCB); send(1, 0, -1);
        idle_drain();
        chk("final_a_ok", {16'd0, a_ok}, 1);
        chk("final_b_err", {16'd0, b_err}, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crc_check_strip.md
Name: crc_check_strip

Overview:
- Receive-side counterpart of the MAC transmit CRC generator.
- Accepts a byte-wide AXI-Stream Ethernet frame with preamble and SFD already removed and the 4-byte FCS still attached.
- Verifies the CRC-32 with the residue method, strips the FCS, and marks bad frames with tuser on the last output beat.
- Sits between the MII receive deframer and the receive frame FIFO.

Parameters:
- MIN_FRAME_BYTES, 64: minimum legal frame length including FCS. Shorter frames of 5 or more bytes are forwarded but flagged with tuser=1 as runts.
- COUNTER_WIDTH, 16: width of the saturating status counters.

Ports:
- clock  input  1  single clock for all logic
- aresetn  input  1  asynchronous active-low reset
- saxis_tdata  input  8  received byte, wire order
- saxis_tvalid  input  1  input beat valid
- saxis_tready  output  1  input beat accepted
- saxis_tlast  input  1  last FCS byte of frame
- saxis_tuser  input  1  PHY error on this byte
- maxis_tdata  output  8  payload byte
- maxis_tvalid  output  1  output beat valid
- maxis_tready  input  1  downstream ready
- maxis_tlast  output  1  last payload byte
- maxis_tuser  output  1  frame bad; meaningful only with maxis_tlast
- status_valid  output  1  one-cycle pulse per completed input frame, including dropped frames
- status_crc_error  output  1  qualified by status_valid: CRC residue mismatch
- status_runt  output  1  qualified by status_valid: length < MIN_FRAME_BYTES
- frame_ok_count  output  COUNTER_WIDTH  frames with tuser=0
- frame_err_count  output  COUNTER_WIDTH  frames with tuser=1 or dropped

Behaviour:
- Reset (async assert, sync deassert):
  - maxis_tvalid/tlast/tuser=0, maxis_tdata=0.
  - Holdback buffer empty.
  - CRC register=0xFFFFFFFF.
  - Byte counter=0, sticky error=0.
  - status_* = 0, counters=0.
- Reset mid-frame discards the partial frame with no output and no status.
- Handshake:
  - saxis_tready = !maxis_tvalid || maxis_tready.
  - A beat transfers when valid && ready.
  - The output register holds data/last/user stable while maxis_tvalid && !maxis_tready.
- Holdback buffer:
  - 4-entry shift register plus a 0..4 fill count.
  - On an accepted beat with fill<4: push the byte, fill++, produce no output.
  - On an accepted beat with fill==4: load the oldest byte into the output register (maxis_tvalid=1 next cycle), then shift in the new byte.
  - Latency from acceptance of byte N+4 to presentation of byte N is 1 cycle.
- Frame end (accepted beat with saxis_tlast):
  - The emitted byte, if any, carries maxis_tlast=1.
  - maxis_tuser = crc_bad || runt || sticky_phy_error, where sticky_phy_error is the OR of saxis_tuser over all frame bytes including this one.
  - After the beat, fill=0, CRC=0xFFFFFFFF, byte counter=0, sticky error=0. The next beat starts a new frame.
- CRC:
  - Reflected CRC-32 (polynomial 0xEDB88320, LSB-first, 8 bit-steps per byte), init all-ones, no final inversion.
  - Updated over every accepted byte including the FCS.
  - crc_bad = (register after the last byte) != 0xDEBB20E3.
- Length:
  - Byte counter counts accepted bytes including the tlast byte and saturates at 0xFFFF.
  - runt = count < MIN_FRAME_BYTES.
- Short frames (count ≤ 4, fill <4 at tlast): no output beats. Status pulses with status_runt=1; frame_err_count increments.
- Status:
  - status_valid pulses the cycle after the tlast beat is accepted, independent of output backpressure.
  - frame_ok_count and frame_err_count update in the same cycle and saturate at all-ones.
- Backpressure: stalls never drop or duplicate bytes. CRC and counters advance only on accepted beats.
- saxis_tvalid with tready=0: no state change.

Test Plan:
- Good frame: bench sets MIN_FRAME_BYTES=5 and sends 31 32 33 34 35 36 37 38 39 26 39 F4 CB with tlast on CB -> 9 output beats 31..39, tlast on 39, tuser=0; status_valid with crc_error=0; frame_ok_count=1.
- Corrupt FCS: same frame with the last byte CA -> same 9 bytes, tuser=1 on 39; status_crc_error=1; frame_err_count=1.
- Runt with default MIN_FRAME_BYTES=64: good 13-byte frame above -> 9 bytes out, tuser=1; status_runt=1, status_crc_error=0.
- Short frame: 3 bytes AA BB CC with tlast -> no maxis_tvalid; status_valid with status_runt=1; frame_err_count increments; following good frame is passed intact.
- Backpressure: random maxis_tready at 30% duty over back-to-back good frames -> byte-exact output, one status per frame, saxis_tready low exactly when maxis_tvalid && !maxis_tready.
- PHY error and reset: saxis_tuser=1 on byte 5 of a good frame -> tuser=1 at end with crc_error=0. aresetn low mid-frame -> all outputs 0 immediately, the next frame is checked correctly.
